// File: rtl/wb_rx_interface_pkg.sv
// Shared types, register map and CRC helpers for the Wishbone RX drain block.
// CRC32 is the reflected Ethernet polynomial; the exposed value is bit-reversed.
package wb_rx_interface_pkg;

  localparam int unsigned ADDR_W  = 2;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned FIFO_W  = DATA_W + 1;
  localparam int unsigned COUNT_W = 11;
  localparam int unsigned CRC_W   = 32;

  localparam logic [COUNT_W-1:0] COUNT_MAX     = COUNT_W'(2047);
  localparam logic [CRC_W-1:0]   CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [CRC_W-1:0]   CRC_POLY_REFL = 32'hEDB88320;

  localparam logic [ADDR_W-1:0] REG_DATA     = 2'd0;
  localparam logic [ADDR_W-1:0] REG_COUNT_LO = 2'd1;
  localparam logic [ADDR_W-1:0] REG_STATUS   = 2'd2;
  localparam logic [ADDR_W-1:0] REG_CTRL     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READING = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // FIFO head word: end-of-frame marker above the data byte
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_word_t;

  typedef struct packed {
    logic                      crc_ok;
    logic                      frame_done;
    logic [2:0]                rsvd;
    logic [COUNT_W-DATA_W-1:0] count_hi;
  } status_reg_t;

  // One byte through the LSB-first CRC register
  function automatic logic [CRC_W-1:0] crc32_byte(input logic [CRC_W-1:0] crc,
                                                  input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[CRC_W-1:1]} ^ (fb ? CRC_POLY_REFL : '0);
    end
    return c;
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == COUNT_MAX) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/wb_rx_interface_if.sv
// Byte-wide Wishbone pipelined bus between the CPU master and the RX drain slave.
interface wb_rx_interface_if;
  import wb_rx_interface_pkg::*;

  logic              i_wb_cyc;
  logic              i_wb_stb;
  logic              i_wb_we;
  logic [ADDR_W-1:0] i_wb_addr;
  logic [DATA_W-1:0] i_wb_data;
  logic              o_wb_ack;
  logic              o_wb_stall;
  logic [DATA_W-1:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data
  );

endinterface

// File: rtl/wb_rx_interface_crc32.sv
// Byte-serial Ethernet CRC32 accumulator; crc is the bit-reversed register so a
// good frame including its FCS leaves CRC_RESIDUE.
module crc32
  import wb_rx_interface_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  output logic [CRC_W-1:0]  crc
);

  logic [CRC_W-1:0] lfsr_q;

  // Synchronous clear: rst is decoded from FSM state and must not glitch a flop reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= '1;
    end else if (en) begin
      lfsr_q <= crc32_byte(lfsr_q, data_in);
    end
  end

  assign crc = {<<{lfsr_q}};

endmodule

// File: rtl/wb_rx_interface.sv
// Wishbone byte slave draining RX frames from a FWFT FIFO, with per-frame byte
// count, FCS check and a software release between frames.
module wb_rx_interface
  import wb_rx_interface_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  wb_rx_interface_if.slave  wb,
  input  logic              i_fifo_empty,
  input  logic [FIFO_W-1:0] i_fifo_data,
  output logic              o_fifo_rd
);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               crc_ok_q, crc_ok_d;
  logic               frame_done_q, frame_done_d;
  logic               ack_q, ack_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  fifo_word_t         head;
  status_reg_t        status_c;
  logic               rd_data_c;
  logic               stall_c;
  logic               accept_c;
  logic               pop_c;
  logic               release_c;
  logic               crc_rst_c;
  logic [CRC_W-1:0]   crc;
  logic               unused_wdata;

  assign head         = fifo_word_t'(i_fifo_data);
  assign unused_wdata = ^wb.i_wb_data;

  // Bus decode: only data-port reads depend on FIFO and frame state
  assign rd_data_c = !wb.i_wb_we && (wb.i_wb_addr == REG_DATA);
  assign stall_c   = (state_q == S_IDLE) ||
                     (rd_data_c && ((state_q != S_READING) || i_fifo_empty));
  assign accept_c  = wb.i_wb_cyc && wb.i_wb_stb && !stall_c;
  assign pop_c     = accept_c && rd_data_c;
  assign release_c = accept_c && wb.i_wb_we && (wb.i_wb_addr == REG_CTRL);
  assign o_fifo_rd = rst && pop_c;

  assign crc_rst_c = !rst || (state_q == S_IDLE);

  crc32 u_crc32 (
    .clk     (clk),
    .rst     (crc_rst_c),
    .en      (pop_c),
    .data_in (head.data),
    .crc     (crc)
  );

  always_comb begin
    status_c            = '0;
    status_c.crc_ok     = crc_ok_q;
    status_c.frame_done = frame_done_q;
    status_c.count_hi   = count_q[COUNT_W-1:DATA_W];
  end

  // Next state, frame bookkeeping and read-data mux
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    crc_ok_d     = crc_ok_q;
    frame_done_d = frame_done_q;
    ack_d        = accept_c;
    rdata_d      = rdata_q;

    if (accept_c && !wb.i_wb_we) begin
      unique case (wb.i_wb_addr)
        REG_DATA:     rdata_d = head.data;
        REG_COUNT_LO: rdata_d = count_q[DATA_W-1:0];
        REG_STATUS:   rdata_d = DATA_W'(status_c);
        default:      rdata_d = {{(DATA_W-1){1'b0}}, !i_fifo_empty};
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        count_d      = '0;
        crc_ok_d     = 1'b0;
        frame_done_d = 1'b0;
        state_d      = S_READING;
      end
      S_READING: begin
        if (pop_c) begin
          count_d = sat_inc(count_q);
          if (head.last) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Last byte entered the CRC on the transition edge; compare once, then hold
        if (!frame_done_q) begin
          frame_done_d = 1'b1;
          crc_ok_d     = (crc == CRC_RESIDUE);
        end
        if (release_c) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      crc_ok_q     <= 1'b0;
      frame_done_q <= 1'b0;
      ack_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      crc_ok_q     <= crc_ok_d;
      frame_done_q <= frame_done_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
    end
  end

  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_stall = stall_c;
  assign wb.o_wb_data  = rdata_q;

endmodule
